// File: rtl/serial_add_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sequencer_pkg
// Purpose  : Shared types and constants for the serial add sequencer:
//            FSM state encoding, adder slice width and a counter-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package serial_add_sequencer_pkg;

  // Bits processed per clock by the adder slice.
  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit,
  // so a single-step sequence still has a legal counter.
  function automatic int cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_sequencer_full_adder_2bit.sv
`default_nettype none
// ============================================================================
// Module   : full_adder_2bit
// Purpose  : Combinational 2-bit ripple full adder; the per-cycle slice of
//            the serial add sequencer.
// Ports    : a[1:0], b[1:0] - operand bit pairs
//            cin            - carry into bit 0
//            s[1:0]         - sum bits
//            cout           - carry out of bit 1
// Revision : 1.0 - initial release
// ============================================================================
module full_adder_2bit
  import serial_add_sequencer_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic w_c0;

  assign s[0] = a[0] ^ b[0] ^ cin;
  assign w_c0 = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
  assign s[1] = a[1] ^ b[1] ^ w_c0;
  assign cout = (a[1] & b[1]) | (a[1] & w_c0) | (b[1] & w_c0);

endmodule
`default_nettype wire

// File: rtl/serial_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sequencer
// Purpose  : Adds two WIDTH-bit unsigned operands plus carry-in by running a
//            single 2-bit full-adder slice for WIDTH/2 cycles, LSB pair first,
//            with the carry held in a flop between cycles.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_valid/in_ready   - operand handshake (ready only in IDLE)
//            a, b, cin           - operands and carry-in
//            out_valid/out_ready - result handshake (valid only in HOLD)
//            sum, cout           - registered result, updated only on
//                                  completion of a sequence
// Params   : WIDTH - operand width, even and >= 2
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               STEPS    = WIDTH / SLICE_W;
  localparam int               CNT_W    = cnt_width(STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_cout;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_load;
  logic               w_step;
  logic               w_done;
  logic [SLICE_W-1:0] w_slice_s;
  logic               w_slice_cout;
  logic [WIDTH-1:0]   w_op_a_shr;
  logic [WIDTH-1:0]   w_op_b_shr;
  logic [WIDTH-1:0]   w_acc_nxt;

  full_adder_2bit u_slice (
    .a    (r_op_a[SLICE_W-1:0]),
    .b    (r_op_b[SLICE_W-1:0]),
    .cin  (r_carry),
    .s    (w_slice_s),
    .cout (w_slice_cout)
  );

  // Operands shift right so the next bit pair is always at [1:0]; the
  // accumulator fills from the top so that after STEPS shifts the first
  // (least significant) pair has reached bit 0.
  generate
    if (WIDTH > SLICE_W) begin : g_multi_step
      assign w_op_a_shr = {{SLICE_W{1'b0}}, r_op_a[WIDTH-1:SLICE_W]};
      assign w_op_b_shr = {{SLICE_W{1'b0}}, r_op_b[WIDTH-1:SLICE_W]};
      assign w_acc_nxt  = {w_slice_s, r_acc[WIDTH-1:SLICE_W]};
    end else begin : g_single_step
      assign w_op_a_shr = '0;
      assign w_op_b_shr = '0;
      assign w_acc_nxt  = w_slice_s;
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_done      = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: operand shifters, accumulator, carry flop, step counter and
  // the result registers, which only move on the final RUN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      if (w_load) begin
        r_op_a  <= a;
        r_op_b  <= b;
        r_carry <= cin;
        r_cnt   <= '0;
      end else if (w_step) begin
        r_op_a  <= w_op_a_shr;
        r_op_b  <= w_op_b_shr;
        r_acc   <= w_acc_nxt;
        r_carry <= w_slice_cout;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
      if (w_done) begin
        r_sum  <= w_acc_nxt;
        r_cout <= w_slice_cout;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_sequencer
// Purpose  : Scoreboard bench for serial_add_sequencer with a WIDTH=8 and a
//            WIDTH=2 instance. Stimulus pushes hand-computed results into
//            queues; monitors pop and compare on every cycle out_valid is up.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_sequencer;

  typedef struct {
    logic [7:0] s;
    logic       c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv8, ir8, ov8, ordy8, ci8, co8;
  logic [7:0] a8, b8, s8;
  logic       iv2, ir2, ov2, ordy2, ci2, co2;
  logic [1:0] a2, b2, s2;

  exp_t exp8_q[$];
  exp_t exp2_q[$];
  int   acc8_q[$];
  int   acc2_q[$];
  int   rise8_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic ov8_d  = 1'b0;
  logic ov2_d  = 1'b0;

  serial_add_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(ci8), .out_valid(ov8), .out_ready(ordy8), .sum(s8), .cout(co8)
  );

  serial_add_sequencer #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .cin(ci2), .out_valid(ov2), .out_ready(ordy2), .sum(s2), .cout(co2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // Edge counter and accept-edge recorder (reads pre-edge handshake values).
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      acc8_q.delete();
      acc2_q.delete();
    end else begin
      if (iv8 && ir8) acc8_q.push_back(cyc);
      if (iv2 && ir2) acc2_q.push_back(cyc);
    end
  end

  // Monitors: compare against scoreboard head while out_valid is high,
  // pop on the cycle the sink accepts.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      ov8_d = 1'b0;
      ov2_d = 1'b0;
    end else begin
      if (ov8) begin
        if (!ov8_d) begin
          rise8_q.push_back(cyc);
          if (acc8_q.size() == 0) fail("lat8_no_accept");
          else chk("lat8", cyc - acc8_q.pop_front(), 4);
        end
        if (exp8_q.size() == 0) begin
          fail("unexpected8");
        end else begin
          chk("sum8", s8, exp8_q[0].s);
          chk("cout8", co8, exp8_q[0].c);
          chk("in_ready8_hold", ir8, 0);
          if (ordy8) void'(exp8_q.pop_front());
        end
      end
      ov8_d = ov8;
      if (ov2) begin
        if (!ov2_d) begin
          if (acc2_q.size() == 0) fail("lat2_no_accept");
          else chk("lat2", cyc - acc2_q.pop_front(), 1);
        end
        if (exp2_q.size() == 0) begin
          fail("unexpected2");
        end else begin
          chk("sum2", s2, exp2_q[0].s[1:0]);
          chk("cout2", co2, exp2_q[0].c);
          if (ordy2) void'(exp2_q.pop_front());
        end
      end
      ov2_d = ov2;
    end
  end

  task automatic wait_ready8();
    int n = 0;
    while (!ir8 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ir8) fail("timeout_in_ready8");
  endtask

  task automatic send8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic [7:0] es, input logic ec, input bit keep);
    exp_t e;
    e.s = es;
    e.c = ec;
    exp8_q.push_back(e);
    a8 = ta; b8 = tb; ci8 = tc; iv8 = 1'b1;
    wait_ready8();
    @(posedge clk); #1;
    if (!keep) iv8 = 1'b0;
  endtask

  task automatic drain8();
    int n = 0;
    while (exp8_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp8_q.size() != 0) fail("timeout_drain8");
  endtask

  task automatic send2(input logic [1:0] ta, input logic [1:0] tb, input logic tc,
                       input logic [1:0] es, input logic ec);
    exp_t e;
    int   n = 0;
    e.s = {6'd0, es};
    e.c = ec;
    exp2_q.push_back(e);
    a2 = ta; b2 = tb; ci2 = tc; iv2 = 1'b1;
    while (!ir2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ir2) fail("timeout_in_ready2");
    @(posedge clk); #1;
    iv2 = 1'b0;
  endtask

  task automatic drain2();
    int n = 0;
    while (exp2_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp2_q.size() != 0) fail("timeout_drain2");
  endtask

  initial begin
    rst = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; ordy8 = 1'b1;
    iv2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0; ordy2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_out_valid8", ov8, 0);
    chk("rst_sum8", s8, 0);
    chk("rst_cout8", co8, 0);
    chk("rst_in_ready8", ir8, 1);
    chk("rst_out_valid2", ov2, 0);
    chk("rst_sum2", s2, 0);
    chk("rst_cout2", co2, 0);
    chk("rst_in_ready2", ir2, 1);

    // Basic and full-ripple vectors
    send8(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    drain8();
    send8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    send8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    drain8();

    // Backpressure with junk operands pulsed while the result is held
    ordy8 = 1'b0;
    send8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
    begin
      int n = 0;
      while (!ov8 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (!ov8) fail("timeout_out_valid8");
    end
    for (int i = 0; i < 10; i++) begin
      a8  = 8'(8'hA0 + i);
      b8  = 8'h0F;
      ci8 = i[1];
      iv8 = i[0];
      @(posedge clk); #1;
    end
    iv8   = 1'b0;
    ordy8 = 1'b1;
    drain8();

    // Reset on the second RUN cycle discards the sequence
    a8 = 8'h77; b8 = 8'h11; ci8 = 1'b0; iv8 = 1'b1;
    wait_ready8();
    @(posedge clk); #1;
    iv8 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid8", ov8, 0);
    chk("midrst_sum8", s8, 0);
    chk("midrst_cout8", co8, 0);
    chk("midrst_in_ready8", ir8, 1);
    send8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    drain8();

    // Back-to-back with in_valid and out_ready held high
    wait_ready8();
    rise8_q.delete();
    send8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b1);
    send8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);
    send8(8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0, 1'b0);
    drain8();
    chk("b2b_count", rise8_q.size(), 3);
    if (rise8_q.size() == 3) begin
      chk("b2b_period_1", rise8_q[1] - rise8_q[0], 6);
      chk("b2b_period_2", rise8_q[2] - rise8_q[1], 6);
    end

    // WIDTH=2 exhaustive
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      logic [2:0] t;
      v = 5'(i);
      t = 3'(v[4:3]) + 3'(v[2:1]) + 3'(v[0]);
      send2(v[4:3], v[2:1], v[0], t[1:0], t[2]);
    end
    drain2();

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
